// File: rtl/ecpd_pkg.sv
// Shared types, micro-op schedule and latency helpers for the
// Jacobian point doubler (ecpd_seq) and its bit-serial multiplier.
package ecpd_pkg;

  typedef enum logic [1:0] {
    OP_MUL,
    OP_ADD,
    OP_SUB
  } op_e;

  typedef enum logic [4:0] {
    R_X, R_Y, R_Z, R_A,
    R_XX, R_YY, R_YZ, R_M,
    R_ZZ, R_Z4, R_W, R_S,
    R_T, R_Z3, R_MM, R_X3,
    R_D, R_E, R_Y3
  } reg_e;

  localparam int NREG = 19;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_DONE
  } state_e;

  typedef logic [4:0] pc_t;

  typedef struct packed {
    op_e  op;
    reg_e dst;
    reg_e src_a;
    reg_e src_b;
    logic mode1_only;
  } uop_t;

  localparam pc_t SCHED_LEN = 5'd23;
  // first entry after the general-a block
  localparam pc_t M1_END = 5'd9;

  localparam uop_t UOP_NOP = '{OP_ADD, R_X, R_X, R_X, 1'b0};

  localparam uop_t SCHED [23] = '{
    '{OP_MUL, R_XX, R_X,  R_X,  1'b0},
    '{OP_MUL, R_YY, R_Y,  R_Y,  1'b0},
    '{OP_MUL, R_YZ, R_Y,  R_Z,  1'b0},
    '{OP_ADD, R_M,  R_XX, R_XX, 1'b0},
    '{OP_ADD, R_M,  R_M,  R_XX, 1'b0},
    '{OP_MUL, R_ZZ, R_Z,  R_Z,  1'b1},
    '{OP_MUL, R_Z4, R_ZZ, R_ZZ, 1'b1},
    '{OP_MUL, R_W,  R_A,  R_Z4, 1'b1},
    '{OP_ADD, R_M,  R_M,  R_W,  1'b1},
    '{OP_MUL, R_S,  R_X,  R_YY, 1'b0},
    '{OP_ADD, R_S,  R_S,  R_S,  1'b0},
    '{OP_ADD, R_S,  R_S,  R_S,  1'b0},
    '{OP_MUL, R_T,  R_YY, R_YY, 1'b0},
    '{OP_ADD, R_T,  R_T,  R_T,  1'b0},
    '{OP_ADD, R_T,  R_T,  R_T,  1'b0},
    '{OP_ADD, R_T,  R_T,  R_T,  1'b0},
    '{OP_ADD, R_Z3, R_YZ, R_YZ, 1'b0},
    '{OP_MUL, R_MM, R_M,  R_M,  1'b0},
    '{OP_SUB, R_X3, R_MM, R_S,  1'b0},
    '{OP_SUB, R_X3, R_X3, R_S,  1'b0},
    '{OP_SUB, R_D,  R_S,  R_X3, 1'b0},
    '{OP_MUL, R_E,  R_M,  R_D,  1'b0},
    '{OP_SUB, R_Y3, R_E,  R_T,  1'b0}
  };

  function automatic uop_t uop_at(input pc_t i);
    uop_t u;
    u = UOP_NOP;
    if (i < SCHED_LEN) u = SCHED[i];
    return u;
  endfunction

  function automatic int lat_mode0(input int w);
    return 7 * (w + 1) + 14;
  endfunction

  function automatic int lat_mode1(input int w);
    return 10 * (w + 1) + 15;
  endfunction

endpackage

// File: rtl/ecpd_seq_if.sv
// Start/operand/result bundle of the point doubler.
// master drives start + operands, slave returns busy/done/results.
interface ecpd_seq_if #(
  parameter int WIDTH = 256
);
  logic             i_start;
  logic             i_mode;
  logic [WIDTH-1:0] i_x1;
  logic [WIDTH-1:0] i_y1;
  logic [WIDTH-1:0] i_z1;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_p;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_x3;
  logic [WIDTH-1:0] o_y3;
  logic [WIDTH-1:0] o_z3;

  modport master (
    output i_start, i_mode,
    output i_x1, i_y1, i_z1, i_a, i_p,
    input  o_busy, o_done,
    input  o_x3, o_y3, o_z3
  );

  modport slave (
    input  i_start, i_mode,
    input  i_x1, i_y1, i_z1, i_a, i_p,
    output o_busy, o_done,
    output o_x3, o_y3, o_z3
  );
endinterface

// File: rtl/ecpd_modmul.sv
// Interleaved MSB-first bit-serial modular multiplier, WIDTH+1 cycles.
// i_start loads a,b,p; o_done/o_prod are valid in the last iteration.
module ecpd_modmul #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_p,
  output logic [WIDTH-1:0] o_prod,
  output logic             o_done
);
  localparam int CW = $clog2(WIDTH);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(WIDTH - 1);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  cnt_t             cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [WIDTH:0]   t1, t2, pw;
  logic [WIDTH-1:0] t1r, t3, addend;

  always_comb begin
    pw     = {1'b0, p_q};
    t1     = {acc_q, 1'b0};
    t1r    = (t1 >= pw) ? WIDTH'(t1 - pw)
                        : t1[WIDTH-1:0];
    addend = b_q[WIDTH-1] ? a_q : '0;
    t2     = {1'b0, t1r} + {1'b0, addend};
    t3     = (t2 >= pw) ? WIDTH'(t2 - pw)
                        : t2[WIDTH-1:0];
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    o_done = 1'b0;
    if (i_start) begin
      a_d   = i_a;
      b_d   = i_b;
      p_d   = i_p;
      acc_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = t3;
      b_d   = b_q << 1;
      cnt_d = cnt_q + cnt_t'(1);
      if (cnt_q == CNT_LAST) begin
        run_d  = 1'b0;
        o_done = 1'b1;
      end
    end
  end

  assign o_prod = t3;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      p_q   <= p_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/ecpd_seq.sv
// Jacobian EC point doubler: one bit-serial multiplier + inline add/sub
// stepped through a fixed micro-op schedule.
// Ports: i_clk, i_rst_n (async low), bus (ecpd_seq_if.slave):
//   i_start/i_mode/i_x1/i_y1/i_z1/i_a/i_p in; o_busy/o_done/o_x3/o_y3/o_z3 out.
// Option macro ECPD_INF_EN: Y1==0 or Z1==0 returns (1,1,0) right after LOAD.
module ecpd_seq #(
  parameter int WIDTH = 256
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  ecpd_seq_if.slave bus
);
  import ecpd_pkg::*;

  localparam int LAT_MODE0 = lat_mode0(WIDTH);
  localparam int LAT_MODE1 = lat_mode1(WIDTH);

  if (WIDTH < 4 || LAT_MODE1 <= LAT_MODE0) begin : g_bad_width
    $error("ecpd_seq: WIDTH must be >= 4");
  end

  state_e           state_q, state_d;
  pc_t              pc_q, pc_d;
  logic             mul_busy_q, mul_busy_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] x3_q, x3_d;
  logic [WIDTH-1:0] y3_q, y3_d;
  logic [WIDTH-1:0] z3_q, z3_d;
  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rf_d [NREG];

  uop_t             cur, nuop;
  pc_t              nxt_pc;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] add_res, sub_res, alu_res;
  logic [WIDTH-1:0] mul_prod, wr_data;
  logic             mul_start, mul_done, wr_en;

  always_comb begin
    cur  = uop_at(pc_q);
    opa  = rf_q[cur.src_a];
    opb  = rf_q[cur.src_b];
    sum  = {1'b0, opa} + {1'b0, opb};
    add_res = (sum >= {1'b0, p_q})
            ? WIDTH'(sum - {1'b0, p_q})
            : sum[WIDTH-1:0];
    diff = {1'b0, opa} - {1'b0, opb};
    sub_res = diff[WIDTH]
            ? diff[WIDTH-1:0] + p_q
            : diff[WIDTH-1:0];
    unique case (1'b1)
      cur.op == OP_SUB: alu_res = sub_res;
      default:          alu_res = add_res;
    endcase
    // general-a block costs nothing when a==0
    nxt_pc = pc_q + 5'd1;
    nuop   = uop_at(nxt_pc);
    if (!mode_q && nuop.mode1_only)
      nxt_pc = M1_END;
  end

  ecpd_modmul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(mul_start),
    .i_a    (opa),
    .i_b    (opb),
    .i_p    (p_q),
    .o_prod (mul_prod),
    .o_done (mul_done)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mul_busy_d = mul_busy_q;
    mode_d     = mode_q;
    p_d        = p_q;
    x3_d       = x3_q;
    y3_d       = y3_q;
    z3_d       = z3_q;
    rf_d       = rf_q;
    mul_start  = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d   = S_LOAD;
          mode_d    = bus.i_mode;
          p_d       = bus.i_p;
          rf_d[R_X] = bus.i_x1;
          rf_d[R_Y] = bus.i_y1;
          rf_d[R_Z] = bus.i_z1;
          rf_d[R_A] = bus.i_a;
        end
      end
      S_LOAD: begin
        pc_d       = '0;
        mul_busy_d = 1'b0;
        state_d    = S_EXEC;
`ifdef ECPD_INF_EN
        if (rf_q[R_Z] == '0 || rf_q[R_Y] == '0) begin
          state_d = S_DONE;
          x3_d    = WIDTH'(1);
          y3_d    = WIDTH'(1);
          z3_d    = '0;
        end
`endif
      end
      S_EXEC: begin
        if (cur.op == OP_MUL) begin
          if (!mul_busy_q) begin
            mul_start  = 1'b1;
            mul_busy_d = 1'b1;
          end else if (mul_done) begin
            mul_busy_d = 1'b0;
            wr_en      = 1'b1;
            wr_data    = mul_prod;
          end
        end else begin
          wr_en   = 1'b1;
          wr_data = alu_res;
        end
        if (wr_en) begin
          rf_d[cur.dst] = wr_data;
          if (pc_q == SCHED_LEN - 5'd1) begin
            state_d = S_DONE;
            x3_d    = rf_d[R_X3];
            y3_d    = rf_d[R_Y3];
            z3_d    = rf_d[R_Z3];
          end else begin
            pc_d = nxt_pc;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      mul_busy_q <= 1'b0;
      mode_q     <= 1'b0;
      p_q        <= '0;
      x3_q       <= '0;
      y3_q       <= '0;
      z3_q       <= '0;
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mul_busy_q <= mul_busy_d;
      mode_q     <= mode_d;
      p_q        <= p_d;
      x3_q       <= x3_d;
      y3_q       <= y3_d;
      z3_q       <= z3_d;
      rf_q       <= rf_d;
    end
  end

  assign bus.o_busy = (state_q != S_IDLE);
  assign bus.o_done = (state_q == S_DONE);
  assign bus.o_x3   = x3_q;
  assign bus.o_y3   = y3_q;
  assign bus.o_z3   = z3_q;

endmodule

// File: tb/tb_ecpd_seq.sv
// Bench for ecpd_seq: WIDTH=8 (small primes) and WIDTH=256
// (secp256k1) instances against a formula-level doubling model.
module tb_ecpd_seq;

  localparam logic [255:0] P_K1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] GX =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] GY =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ecpd_seq_if #(.WIDTH(8))   if8 ();
  ecpd_seq_if #(.WIDTH(256)) if256 ();

  ecpd_seq #(.WIDTH(8)) u8 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (if8.slave)
  );

  ecpd_seq #(.WIDTH(256)) u256 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (if256.slave)
  );

  int nvec = 0;
  int nfail = 0;
  int unsigned primes [5] = '{13, 23, 97, 241, 251};

  task automatic chk(input string tag, input string fld,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s.%s observed=%0h expected=%0h",
             tag, fld, obs, exp);
    end
  endtask

  function automatic logic [255:0] fm(input logic [255:0] a, b, p);
    logic [511:0] t;
    t = ({256'd0, a} * {256'd0, b}) % {256'd0, p};
    return t[255:0];
  endfunction

  function automatic logic [255:0] fs(input logic [255:0] a, b, p);
    logic [257:0] t;
    t = ({2'b0, a} + {2'b0, p} - {2'b0, b}) % {2'b0, p};
    return t[255:0];
  endfunction

  // 2*(x,y,z): M=3x^2+a z^4, S=4xy^2, X3=M^2-2S, Y3=M(S-X3)-8y^4, Z3=2yz
  task automatic ref_dbl(input bit md,
                         input logic [255:0] x, y, z, a, p,
                         output logic [255:0] x3, y3, z3);
    logic [255:0] yy, m, s, t, z4;
    yy = fm(y, y, p);
    m  = fm(256'd3, fm(x, x, p), p);
    if (md) begin
      z4 = fm(fm(z, z, p), fm(z, z, p), p);
      m  = (m + fm(a, z4, p)) % p;
    end
    s  = fm(256'd4, fm(x, yy, p), p);
    t  = fm(256'd8, fm(yy, yy, p), p);
    x3 = fs(fm(m, m, p), fm(256'd2, s, p), p);
    y3 = fs(fm(m, fs(s, x3, p), p), t, p);
    z3 = fm(256'd2, fm(y, z, p), p);
`ifdef ECPD_INF_EN
    if (y == 0 || z == 0) begin
      x3 = 256'd1;
      y3 = 256'd1;
      z3 = 256'd0;
    end
`endif
  endtask

  function automatic int exp_lat(input bit w8, input bit md,
                                 input logic [255:0] y, z);
    int w;
    w = w8 ? 8 : 256;
`ifdef ECPD_INF_EN
    if (y == 0 || z == 0) return 2;
`else
    if (y == z && y != y) return 0;
`endif
    return md ? 10 * (w + 1) + 15 : 7 * (w + 1) + 14;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input bit w8, input bit st, input bit md,
                       input logic [255:0] x, y, z, a, p);
    if (w8) begin
      if8.i_start = st;
      if8.i_mode  = md;
      if8.i_x1    = x[7:0];
      if8.i_y1    = y[7:0];
      if8.i_z1    = z[7:0];
      if8.i_a     = a[7:0];
      if8.i_p     = p[7:0];
    end else begin
      if256.i_start = st;
      if256.i_mode  = md;
      if256.i_x1    = x;
      if256.i_y1    = y;
      if256.i_z1    = z;
      if256.i_a     = a;
      if256.i_p     = p;
    end
  endtask

  task automatic set_start(input bit w8, input bit st);
    if (w8) if8.i_start = st;
    else    if256.i_start = st;
  endtask

  function automatic bit is_busy(input bit w8);
    return w8 ? if8.o_busy : if256.o_busy;
  endfunction

  function automatic bit is_done(input bit w8);
    return w8 ? if8.o_done : if256.o_done;
  endfunction

  task automatic get_out(input bit w8,
                         output logic [255:0] ox, oy, oz);
    if (w8) begin
      ox = {248'd0, if8.o_x3};
      oy = {248'd0, if8.o_y3};
      oz = {248'd0, if8.o_z3};
    end else begin
      ox = if256.o_x3;
      oy = if256.o_y3;
      oz = if256.o_z3;
    end
  endtask

  // Entered at #1 after an edge; returns at #1 in the cycle after DONE.
  task automatic run_op(input bit w8, input bit md,
                        input logic [255:0] x, y, z, a, p,
                        input bit glitch, input string tag,
                        output logic [255:0] ox, oy, oz);
    logic [255:0] ex, ey, ez;
    int lat, el, blow;
    ref_dbl(md, x, y, z, a, p, ex, ey, ez);
    el = exp_lat(w8, md, y, z);
    drive(w8, 1'b1, md, x, y, z, a, p);
    @(posedge clk); #1;
    drive(w8, 1'b0, 1'($urandom), rnd256(), rnd256(),
          rnd256(), rnd256(), rnd256());
    lat  = 1;
    blow = 0;
    while (!is_done(w8) && lat < el + 40) begin
      if (!is_busy(w8)) blow++;
      set_start(w8, glitch && lat == 4);
      @(posedge clk); #1;
      lat++;
    end
    set_start(w8, 1'b0);
    if (!is_busy(w8)) blow++;
    get_out(w8, ox, oy, oz);
    chk(tag, "latency", lat, el);
    chk(tag, "busy_low", blow, 0);
    chk(tag, "x3", ox, ex);
    chk(tag, "y3", oy, ey);
    chk(tag, "z3", oz, ez);
    if (glitch) set_start(w8, 1'b1);
    @(posedge clk); #1;
    set_start(w8, 1'b0);
    if (glitch) begin
      @(posedge clk); #1;
      chk(tag, "busy_after_done", is_busy(w8), 0);
      chk(tag, "done_after_done", is_done(w8), 0);
      get_out(w8, ex, ey, ez);
      chk(tag, "x3_hold", ex, ox);
    end
  endtask

  logic [255:0] ox, oy, oz, rx, ry, rz, ra, rp;
  int nd;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset", "busy8", if8.o_busy, 0);
    chk("reset", "done8", if8.o_done, 0);
    get_out(1'b1, ox, oy, oz);
    chk("reset", "out8", ox | oy | oz, 0);
    chk("reset", "busy256", if256.o_busy, 0);
    get_out(1'b0, ox, oy, oz);
    chk("reset", "out256", ox | oy | oz, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1, 1, 3, 10, 1, 1, 23, 0, "p23m1", ox, oy, oz);
    chk("p23m1", "x3_const", ox, 17);
    chk("p23m1", "y3_const", oy, 21);
    chk("p23m1", "z3_const", oz, 20);
    run_op(1, 0, 3, 10, 1, 0, 23, 0, "p23m0", ox, oy, oz);
    chk("p23m0", "x3_const", ox, 8);
    chk("p23m0", "y3_const", oy, 1);
    chk("p23m0", "z3_const", oz, 20);
    run_op(1, 1, 5, 7, 9, 4, 23, 1, "glitch_m1", ox, oy, oz);
    run_op(1, 0, 11, 2, 6, 0, 13, 1, "glitch_m0", ox, oy, oz);

    drive(1, 1, 1, 3, 10, 1, 1, 23);
    @(posedge clk); #1;
    set_start(1, 1'b0);
    repeat (20) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst", "busy", if8.o_busy, 0);
    get_out(1'b1, ox, oy, oz);
    chk("midrst", "outs", ox | oy | oz, 0);
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (if8.o_done) nd++;
    end
    chk("midrst", "no_done", nd, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1, 1, 3, 10, 1, 1, 23, 0, "post_rst", ox, oy, oz);

    run_op(1, 1, 3, 10, 0, 1, 23, 0, "z_zero", ox, oy, oz);
    run_op(1, 0, 4, 0, 5, 0, 23, 0, "y_zero", ox, oy, oz);
    run_op(1, 0, 0, 6, 2, 0, 97, 0, "x_zero", ox, oy, oz);

    for (int i = 0; i < 30; i++) begin
      int unsigned pv;
      pv = primes[$urandom_range(0, 4)];
      rp = 256'(pv);
      rx = 256'($urandom_range(0, pv - 1));
      ry = 256'($urandom_range(0, pv - 1));
      rz = 256'($urandom_range(0, pv - 1));
      ra = 256'($urandom_range(0, pv - 1));
      run_op(1, 1'($urandom), rx, ry, rz, ra, rp,
             0, "rnd8", ox, oy, oz);
    end

    run_op(0, 0, GX, GY, 1, 0, P_K1, 0, "k1_G", ox, oy, oz);
    for (int i = 0; i < 4; i++) begin
      rx = rnd256() % P_K1;
      ry = rnd256() % P_K1;
      rz = rnd256() % P_K1;
      run_op(0, 0, rx, ry, rz, 0, P_K1, 0, "k1_rnd", ox, oy, oz);
    end
    ra = rnd256() % P_K1;
    run_op(0, 1, GX, GY, rnd256() % P_K1, ra, P_K1, 1,
           "k1_m1", ox, oy, oz);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
